// File: rtl/shift_seq_if.sv
// Command/feedback bus between the shift sequencer and its driver side.
interface shift_seq_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMTW  = 4
);
  logic             start;
  logic [1:0]       op;
  logic [AMTW-1:0]  amt;
  logic             fill;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] q_fb;
  logic [1:0]       s;
  logic [WIDTH-1:0] din;
  logic             slsi;
  logic             srsi;
  logic             busy;
  logic             done;

  modport master (
    output start, op, amt, fill, data_in, q_fb,
    input  s, din, slsi, srsi, busy, done
  );

  modport slave (
    input  start, op, amt, fill, data_in, q_fb,
    output s, din, slsi, srsi, busy, done
  );
endinterface

// File: rtl/shift_seq.sv
// Sequencer that loads an operand into an 8-bit universal shift register and
// then shifts or rotates it a clamped number of places.
module shift_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AMTW  = 4
) (
  input  logic       clk,
  input  logic       clrn,
  shift_seq_if.slave bus
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [CNTW-1:0]  cnt, cnt_nx;
  logic [CNTW-1:0]  amt_q, amt_clamp;
  logic [1:0]       op_q;
  logic             fill_q;
  logic [WIDTH-1:0] din_q;
  logic [1:0]       s_q, s_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             slsi, srsi;
  logic             accept;

  assign accept = (state == IDLE) && bus.start;

  // Clamp requested shift count to the register width.
  always_comb begin
    amt_clamp = CNTW'(bus.amt);
    if (32'(bus.amt) > WIDTH) amt_clamp = CNTW'(WIDTH);
  end

  // Next state, counter and registered Moore outputs decoded from next state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    s_nx     = 2'b00;
    busy_nx  = 1'b0;
    done_nx  = 1'b0;
    case (state)
      IDLE:  if (bus.start) state_nx = LOAD;
      LOAD: begin
        cnt_nx   = amt_q;
        state_nx = (amt_q != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        cnt_nx = cnt - CNTW'(1);
        if (cnt == CNTW'(1)) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    case (state_nx)
      LOAD: begin
        s_nx    = 2'b11;
        busy_nx = 1'b1;
      end
      SHIFT: begin
        // op[0] selects right-going operations
        s_nx    = op_q[0] ? 2'b10 : 2'b01;
        busy_nx = 1'b1;
      end
      DONE: begin
        done_nx = 1'b1;
        busy_nx = 1'b1;
      end
      default: ;
    endcase
  end

  // Serial inputs follow live feedback so rotates wrap the current MSB/LSB.
  always_comb begin
    slsi = 1'b0;
    srsi = 1'b0;
    if (state == SHIFT) begin
      case (op_q)
        2'b00:   slsi = fill_q;
        2'b01:   srsi = fill_q;
        2'b10:   slsi = bus.q_fb[WIDTH-1];
        default: srsi = bus.q_fb[0];
      endcase
    end
  end

  // State, counter, command latches and output registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state  <= IDLE;
      cnt    <= '0;
      amt_q  <= '0;
      op_q   <= '0;
      fill_q <= 1'b0;
      din_q  <= '0;
      s_q    <= 2'b00;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      s_q    <= s_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      if (accept) begin
        amt_q  <= amt_clamp;
        op_q   <= bus.op;
        fill_q <= bus.fill;
        din_q  <= bus.data_in;
      end
    end
  end

  assign bus.s    = s_q;
  assign bus.din  = din_q;
  assign bus.slsi = slsi;
  assign bus.srsi = srsi;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: doc/shift_seq.md
Name: shift_seq

Overview:
- Command sequencer sitting directly upstream of the 8-bit universal shift register (modes: 00 hold, 01 shift left, 10 shift right, 11 parallel load).
- Accepts a one-cycle start command carrying an operand, operation and shift amount. Drives the register's mode select, parallel data and serial-in pins to load the operand, then shift or rotate it the requested number of places.
- Reads the register's parallel output back for rotate feedback.
- Signals busy while sequencing and pulses done when the register holds the result.

Parameters:
- WIDTH, 8, data width; must match the shift register width.
- AMTW, 4, width of the shift-amount field; amounts are clamped to WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clrn  input  1  asynchronous active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- op  input  2  operation: 00 logical left, 01 logical right, 10 rotate left, 11 rotate right.
- amt  input  AMTW  shift count, 0..2^AMTW-1.
- fill  input  1  bit shifted in for logical ops.
- data_in  input  WIDTH  operand to load.
- q_fb  input  WIDTH  shift register parallel output (feedback).
- s  output  2  mode select to shift register.
- din  output  WIDTH  parallel load data to shift register.
- slsi  output  1  serial input for left shift (enters bit 0).
- srsi  output  1  serial input for right shift (enters bit WIDTH-1).
- busy  output  1  high from the cycle after start is accepted until done has been asserted.
- done  output  1  one-cycle pulse; q_fb holds the final result in this cycle.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE; s=00; din=0; slsi=0; srsi=0; busy=0; done=0.
  - Latched op/amt/fill/counter are cleared.
  - Reset mid-operation aborts the command with no done pulse. The shift register shares clrn and clears too.
- FSM states: IDLE, LOAD, SHIFT, DONE. Outputs s, busy and done are decoded from registered state (Moore).
- IDLE:
  - s=00, busy=0.
  - On a rising edge with start=1: latch data_in, op, fill; latch amt clamped to min(amt, WIDTH); go to LOAD.
- LOAD (exactly 1 cycle):
  - s=11, din=latched operand, busy=1.
  - The shift register loads at the edge ending this cycle.
  - Next state is SHIFT if the clamped amount > 0, else DONE.
  - The counter is loaded with the clamped amount.
- SHIFT (exactly clamped-amount cycles):
  - s=01 for op 00/10; s=10 for op 01/11. busy=1.
  - Counter decrements each edge; leave to DONE when it reaches 1 at an edge.
- Serial inputs (combinational, valid in SHIFT):
  - op 00: slsi=fill. op 01: srsi=fill.
  - op 10: slsi=q_fb[WIDTH-1]. op 11: srsi=q_fb[0].
  - The unused serial pin is 0. Both pins are 0 outside SHIFT.
- DONE (1 cycle):
  - s=00, done=1, busy=1. Then go to IDLE.
  - start is accepted again only in IDLE, i.e. the cycle after DONE at the earliest.
- Latency: start sampled at edge k → done high in cycle k+2+N, where N = clamped amount. Total occupancy is N+2 cycles.
- start while busy is ignored with no queuing. Inputs other than q_fb are don't-care after acceptance.
- din holds the latched operand from LOAD until the next accepted command.

Test Plan:
- data_in=0xA5, op=10, amt=3 → s sequence 11,01,01,01,00. done in cycle k+5; q_fb=0x2D.
- data_in=0x81, op=01, amt=2, fill=0 → q_fb=0x20 at done. With fill=1 → 0xE0.
- data_in=0x3C, op=11, amt=8 → exactly 8 SHIFT cycles; q_fb=0x3C at done.
- amt=0, data_in=0x5A → LOAD then DONE immediately; done in cycle k+2; q_fb=0x5A.
- amt=12, op=00, fill=0, data_in=0xFF → clamped to 8; q_fb=0x00 at done. A second start pulsed during SHIFT is ignored, producing no extra done.
- clrn pulsed low during SHIFT of a 0xA5 rotate → all outputs are 0 immediately, state is IDLE, no done. A subsequent command completes normally.
